// File: rtl/booth_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : booth_accumulator
// Purpose  : Saturating frame accumulator fed by Booth multiplier done pulses,
//            with a one-entry valid/ready result slot.
// Revision : 1.0
// ============================================================================
module booth_accumulator #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 12,
    parameter int COUNT_N = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] mul_product,
    input  logic              mul_done,
    input  logic              clear,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_sat,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              overrun,
    output logic [7:0]        prod_cnt
);

    localparam int              c_SUM_W = ACC_W + 1;
    localparam logic [7:0]      c_LAST  = 8'(COUNT_N - 1);
    localparam logic [ACC_W-1:0] c_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_t;

    logic [ACC_W-1:0] r_acc;
    logic             r_fsat;
    logic [7:0]       r_cnt;
    logic             r_done_d;
    logic [ACC_W-1:0] r_acc_out;
    logic             r_acc_sat;
    logic             r_overrun;
    slot_t            r_slot;

    logic             w_ev;
    logic [c_SUM_W-1:0] w_prod_ext;
    logic [c_SUM_W-1:0] w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_sat_val;
    logic             w_complete;
    logic             w_xfer;

    assign w_ev       = mul_done & ~r_done_d;
    assign w_prod_ext = {{(c_SUM_W-PROD_W){mul_product[PROD_W-1]}}, mul_product};
    assign w_sum      = {r_acc[ACC_W-1], r_acc} + w_prod_ext;
    // The extra sum bit disagrees with the ACC_W sign bit exactly on overflow.
    assign w_ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_sat_val  = w_ovf ? (w_sum[ACC_W] ? c_MIN : c_MAX) : w_sum[ACC_W-1:0];
    assign w_complete = w_ev & ~clear & (r_cnt == c_LAST);
    assign w_xfer     = (r_slot == SLOT_FULL) & acc_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc     <= '0;
            r_fsat    <= 1'b0;
            r_cnt     <= 8'd0;
            r_done_d  <= 1'b1;
            r_acc_out <= '0;
            r_acc_sat <= 1'b0;
            r_overrun <= 1'b0;
            r_slot    <= SLOT_EMPTY;
        end else begin
            r_done_d <= mul_done;

            if (clear || w_complete) begin
                r_acc  <= '0;
                r_fsat <= 1'b0;
                r_cnt  <= 8'd0;
            end else if (w_ev) begin
                r_acc  <= w_sat_val;
                r_fsat <= r_fsat | w_ovf;
                r_cnt  <= r_cnt + 8'd1;
            end

            // A same-cycle transfer frees the slot for the new result.
            if (w_complete) begin
                if (r_slot == SLOT_EMPTY || acc_ready) begin
                    r_acc_out <= w_sat_val;
                    r_acc_sat <= r_fsat | w_ovf;
                    r_slot    <= SLOT_FULL;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_xfer) begin
                r_slot <= SLOT_EMPTY;
            end
        end
    end

    assign acc_out   = r_acc_out;
    assign acc_sat   = r_acc_sat;
    assign acc_valid = (r_slot == SLOT_FULL);
    assign overrun   = r_overrun;
    assign prod_cnt  = r_cnt;

endmodule
`default_nettype wire
